// File: rtl/dec_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface dec_rr_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [0:3] grant;
    logic       timeout;

    modport master (output req, done, input gnt_valid, gnt_id, grant, timeout);
    modport slave  (input req, done, output gnt_valid, gnt_id, grant, timeout);
endinterface

// File: rtl/dec_rr_arbiter.sv
// Four-way round-robin arbiter with registered index/enable and one-hot select.
// Define ARB_TIMEOUT_EN to bound each grant to TIMEOUT cycles with a forced release.
module dec_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    dec_rr_arbiter_if.slave   bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dec_rr_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic {S_IDLE, S_GRANT} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [0:3] grant_q, grant_d;
    logic       timeout_q, timeout_d;
    logic [1:0] pick;
    logic       pick_vld;
    logic       release_c;
    logic       force_c;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                pick     = ptr_q + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

    assign release_c = (state_q == S_GRANT) && (bus.done || !bus.req[gnt_id_q]);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    // hold_q counts completed GRANT cycles; the TIMEOUT-th cycle ends the grant.
    assign force_c = (state_q == S_GRANT) && !release_c && (hold_q == 8'(TIMEOUT - 1));
    assign hold_d  = (state_q == S_GRANT) ? hold_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) hold_q <= 8'd0;
        else     hold_q <= hold_d;
    end
`else
    assign force_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            grant_q     <= 4'b0000;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            grant_q     <= grant_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld)              state_d = S_GRANT;
            S_GRANT: if (release_c || force_c)  state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        if (state_q == S_IDLE && pick_vld) begin
            gnt_id_d    = pick;
            gnt_valid_d = 1'b1;
        end
        if (state_q == S_GRANT && (release_c || force_c)) begin
            gnt_valid_d = 1'b0;
            ptr_d       = gnt_id_q + 2'd1;
            timeout_d   = force_c;
        end
        for (int i = 0; i < 4; i++) begin
            grant_d[i] = gnt_valid_d && (gnt_id_d == 2'(i));
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.grant     = grant_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed + randomized bench for dec_rr_arbiter against an ownership-level model.
module tb_dec_rr_arbiter;
    localparam int TIMEOUT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dec_rr_arbiter_if bus();

    dec_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: who owns the slot (-1 = nobody), where the search starts, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input logic [3:0] q, input bit d);
        bit rel, forced;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0; m_last = 0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            rel    = d || !q[m_owner];
            forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
            forced = !rel && (m_held >= TIMEOUT);
`endif
            if (rel || forced) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_to    = forced;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] q, input bit d);
        logic [0:3] eg;
        rst = r; bus.req = q; bus.done = d;
        @(posedge clk);
        model_edge(r, q, d);
        #1;
        eg = 4'b0000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("m_valid",   {7'd0, bus.gnt_valid}, {7'd0, m_owner >= 0});
        chk("m_id",      {6'd0, bus.gnt_id},    8'(m_last));
        chk("m_grant",   {4'd0, bus.grant},     {4'd0, eg});
        chk("m_timeout", {7'd0, bus.timeout},   {7'd0, m_to});
        chk("onehot0",   8'($countones(bus.grant) <= 1), 8'd1);
    endtask

    initial begin
        logic [3:0] rq;

        // Reset with all requesting
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111, 1'b0);
            chk("rst_grant", {4'd0, bus.grant}, 8'h00);
            chk("rst_valid", {7'd0, bus.gnt_valid}, 8'h00);
        end
        step(1'b0, 4'b1111, 1'b0);
        chk("first_grant", {4'd0, bus.grant}, 8'b1000);
        step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Single requester, four grant cycles then done
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0100, 1'b0);
            chk("single_grant", {4'd0, bus.grant}, 8'b0010);
            chk("single_id", {6'd0, bus.gnt_id}, 8'd2);
        end
        step(1'b0, 4'b0100, 1'b1);
        chk("single_rel", {4'd0, bus.grant}, 8'h00);
        step(1'b0, 4'b1111, 1'b0);
        chk("after_single", {6'd0, bus.gnt_id}, 8'd3);
        step(1'b0, 4'b1111, 1'b1);

        // Full rotation, one-cycle grants separated by one idle cycle
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b0);
            chk("rot_id", {6'd0, bus.gnt_id}, 8'(i % 4));
            chk("rot_valid", {7'd0, bus.gnt_valid}, 8'd1);
            step(1'b0, 4'b1111, 1'b1);
            chk("rot_bubble", {7'd0, bus.gnt_valid}, 8'd0);
        end

        // Request drop acts as release
        step(1'b0, 4'b1010, 1'b0);
        chk("drop_id1", {6'd0, bus.gnt_id}, 8'd1);
        step(1'b0, 4'b1000, 1'b0);
        chk("drop_rel", {7'd0, bus.gnt_valid}, 8'd0);
        step(1'b0, 4'b1000, 1'b0);
        chk("drop_grant3", {4'd0, bus.grant}, 8'b0001);
        step(1'b0, 4'b0000, 1'b0);

        // Held request with no done
        step(1'b0, 4'b0011, 1'b0);
        chk("hold_id0", {6'd0, bus.gnt_id}, 8'd0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1'b0, 4'b0011, 1'b0);
            chk("to_hold", {4'd0, bus.grant}, 8'b1000);
        end
        step(1'b0, 4'b0011, 1'b0);
        chk("to_pulse", {7'd0, bus.timeout}, 8'd1);
        chk("to_rel", {7'd0, bus.gnt_valid}, 8'd0);
        step(1'b0, 4'b0011, 1'b0);
        chk("to_next", {6'd0, bus.gnt_id}, 8'd1);
        chk("to_clear", {7'd0, bus.timeout}, 8'd0);
`else
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0011, 1'b0);
            chk("nto_hold", {4'd0, bus.grant}, 8'b1000);
            chk("nto_pulse", {7'd0, bus.timeout}, 8'd0);
        end
`endif
        step(1'b0, 4'b0000, 1'b0);

        // Reset on the third cycle of a grant to index 2
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        chk("mid_pre", {4'd0, bus.grant}, 8'b0010);
        step(1'b1, 4'b0100, 1'b0);
        chk("mid_rst", {4'd0, bus.grant}, 8'h00);
        step(1'b0, 4'b0101, 1'b0);
        chk("mid_after", {6'd0, bus.gnt_id}, 8'd0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // Randomized traffic; requests tend to persist so grants run long
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 59) == 0, rq, $urandom_range(0, 6) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
